// File: rtl/cam_init_sequencer_if.sv
// ROM table port and SCCB-master write port seen by the init sequencer.
interface cam_init_sequencer_if #(
  parameter int REG_ADDR_WIDTH = 8,
  parameter int TBL_ADDR_WIDTH = 8
);
  localparam int ENTRY_WIDTH = 2 + REG_ADDR_WIDTH + 8;

  logic [TBL_ADDR_WIDTH-1:0] rom_addr;
  logic [ENTRY_WIDTH-1:0]    rom_q;
  logic                      wr_req;
  logic [REG_ADDR_WIDTH-1:0] wr_reg_addr;
  logic [7:0]                wr_data;
  logic                      wr_done;
  logic                      wr_nack;

  modport master (
    output rom_addr,
    input  rom_q,
    output wr_req,
    output wr_reg_addr,
    output wr_data,
    input  wr_done,
    input  wr_nack
  );

  modport slave (
    input  rom_addr,
    output rom_q,
    input  wr_req,
    input  wr_reg_addr,
    input  wr_data,
    output wr_done,
    output wr_nack
  );
endinterface

// File: rtl/cam_init_sequencer.sv
// Walks a sensor init table issuing one SCCB write per entry, with delays, END marker and NACK retry.
// At least 4 clk per write (fetch, ROM wait, decode, request); wr_req is held until the master's wr_done.
module cam_init_sequencer #(
  parameter int REG_ADDR_WIDTH = 8,
  parameter int TBL_ADDR_WIDTH = 8,
  parameter int DELAY_UNIT     = 50000,
  parameter int RETRY_MAX      = 3,
  parameter int ENTRY_WIDTH    = 2 + REG_ADDR_WIDTH + 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  cam_init_sequencer_if.master      bus,
  output logic                      busy,
  output logic                      done,
  output logic                      error,
  output logic [TBL_ADDR_WIDTH-1:0] entry_cnt
);
  localparam int                        RETRY_W   = $clog2(RETRY_MAX + 2);
  localparam logic [RETRY_W-1:0]        RETRY_LIM = RETRY_W'(RETRY_MAX);
  localparam logic [TBL_ADDR_WIDTH-1:0] IDX_LAST  = '1;
  localparam logic [31:0]               DLY_UNIT  = DELAY_UNIT;
  localparam logic [1:0]                CMD_WRITE = 2'b00;
  localparam logic [1:0]                CMD_DELAY = 2'b01;
  localparam logic [1:0]                CMD_END   = 2'b10;

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_WAIT, S_DECODE, S_WRITE,
    S_REGAP, S_DELAY, S_NEXT, S_DONE, S_ERROR
  } state_t;

  state_t                    state;
  state_t                    state_nxt;
  logic [TBL_ADDR_WIDTH-1:0] idx;
  logic [ENTRY_WIDTH-1:0]    entry;
  logic [RETRY_W-1:0]        retry;
  logic [31:0]               dly;
  logic [1:0]                cmd;
  logic [7:0]                value;
  logic                      parked;

  assign cmd    = entry[ENTRY_WIDTH-1 -: 2];
  assign value  = entry[7:0];
  assign parked = (state == S_IDLE) || (state == S_DONE) || (state == S_ERROR);

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE, S_DONE, S_ERROR: if (start) state_nxt = S_FETCH;
      S_FETCH:  state_nxt = S_WAIT;
      S_WAIT:   state_nxt = S_DECODE;
      S_DECODE: begin
        unique case (cmd)
          CMD_WRITE: state_nxt = S_WRITE;
          CMD_DELAY: state_nxt = (value == 8'd0) ? S_NEXT : S_DELAY;
          CMD_END:   state_nxt = S_DONE;
          default:   state_nxt = S_NEXT;
        endcase
      end
      // retry holds the NACKs seen so far; one more beyond the limit is fatal
      S_WRITE: begin
        if (bus.wr_done) begin
          if (!bus.wr_nack)          state_nxt = S_NEXT;
          else if (retry >= RETRY_LIM) state_nxt = S_ERROR;
          else                       state_nxt = S_REGAP;
        end
      end
      S_REGAP:  state_nxt = S_WRITE;
      S_DELAY:  if (dly == 32'd1) state_nxt = S_NEXT;
      S_NEXT:   state_nxt = (idx == IDX_LAST) ? S_ERROR : S_FETCH;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx   <= '0;
      entry <= '0;
      retry <= '0;
      dly   <= '0;
    end else begin
      unique case (state)
        S_IDLE, S_DONE, S_ERROR: if (start) idx <= '0;
        S_WAIT:   entry <= bus.rom_q;
        S_DECODE: begin
          retry <= '0;
          dly   <= {24'd0, value} * DLY_UNIT;
        end
        S_WRITE:  if (bus.wr_done && bus.wr_nack) retry <= retry + RETRY_W'(1);
        S_DELAY:  dly <= dly - 32'd1;
        S_NEXT:   if (idx != IDX_LAST) idx <= idx + TBL_ADDR_WIDTH'(1);
        default:  ;
      endcase
    end
  end

  always_comb begin
    bus.wr_req      = (state == S_WRITE);
    bus.wr_reg_addr = entry[8 +: REG_ADDR_WIDTH];
    bus.wr_data     = value;
    bus.rom_addr    = idx;
    entry_cnt       = idx;
    busy            = !parked;
    done            = (state == S_DONE);
    error           = (state == S_ERROR);
  end
endmodule

// File: tb/tb_cam_init_sequencer.sv
// Runs an 8-bit and a 16-bit sequencer on the same table; writes are scoreboarded against a table-walk model.
module tb_cam_init_sequencer;
  localparam int TW = 3;
  localparam int DU = 10;
  localparam int RM = 3;

  logic clk = 1'b0;
  logic reset;
  logic start;
  always #5 clk = ~clk;

  logic [1:0]  t_cmd   [8];
  logic [15:0] t_addr  [8];
  logic [7:0]  t_val   [8];
  int          nack_plan [8];
  int          ack_dly;

  typedef struct {
    logic [15:0] a;
    logic [7:0]  d;
    int          gap;
  } exp_t;
  exp_t q0[$];
  exp_t q1[$];

  wire [1:0]    busy_w, done_w, err_w, req_w;
  wire [TW-1:0] ecnt_w [2];
  wire [TW-1:0] ra_w   [2];
  wire [15:0]   wa_w   [2];
  wire [7:0]    wd_w   [2];

  int  total = 0;
  int  bad   = 0;
  bit  exp_done, exp_err;
  int  exp_ecnt;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic pop_exp(input int g, output exp_t e, output bit ok);
    ok = 1'b0; e.a = '0; e.d = '0; e.gap = -1;
    if (g == 0) begin
      if (q0.size() > 0) begin e = q0.pop_front(); ok = 1'b1; end
    end else begin
      if (q1.size() > 0) begin e = q1.pop_front(); ok = 1'b1; end
    end
  endtask

  function automatic int qsize(input int g);
    return (g == 0) ? q0.size() : q1.size();
  endfunction

  for (genvar g = 0; g < 2; g++) begin : inst
    localparam int RAW = 8 * (g + 1);

    cam_init_sequencer_if #(.REG_ADDR_WIDTH(RAW), .TBL_ADDR_WIDTH(TW)) sbus ();

    cam_init_sequencer #(
      .REG_ADDR_WIDTH(RAW), .TBL_ADDR_WIDTH(TW), .DELAY_UNIT(DU), .RETRY_MAX(RM)
    ) dut (
      .clk(clk), .reset(reset), .start(start), .bus(sbus),
      .busy(busy_w[g]), .done(done_w[g]), .error(err_w[g]), .entry_cnt(ecnt_w[g])
    );

    assign ra_w[g]  = sbus.rom_addr;
    assign wa_w[g]  = 16'(sbus.wr_reg_addr);
    assign wd_w[g]  = sbus.wr_data;
    assign req_w[g] = sbus.wr_req;

    always @(posedge clk)
      sbus.rom_q <= {t_cmd[sbus.rom_addr], t_addr[sbus.rom_addr][RAW-1:0], t_val[sbus.rom_addr]};

    // SCCB master model: acks after a latency, NACKing as many times as the plan for this entry says
    int tmr, lat, nacked;
    always @(posedge clk) begin
      sbus.wr_done <= 1'b0;
      sbus.wr_nack <= 1'b0;
      if (reset || (start && !busy_w[g])) begin
        tmr = 0;
        nacked = 0;
      end else if (sbus.wr_req && !sbus.wr_done) begin
        if (tmr == 0) lat = (ack_dly > 0) ? ack_dly : int'($urandom_range(1, 5));
        tmr++;
        if (tmr >= lat) begin
          tmr = 0;
          sbus.wr_done <= 1'b1;
          if (nacked < nack_plan[sbus.rom_addr]) begin
            sbus.wr_nack <= 1'b1;
            nacked++;
          end else begin
            nacked = 0;
          end
        end
      end
    end

    int          lowc = 0;
    logic        prev = 1'b0;
    logic [15:0] cur_a;
    logic [7:0]  cur_d;
    bit          unstable;
    exp_t        e;
    bit          ok;
    always @(negedge clk) begin
      if (reset) begin
        lowc = 0;
        prev = 1'b0;
      end else begin
        if (req_w[g] && !prev) begin
          pop_exp(g, e, ok);
          chk($sformatf("write_expected[%0d]", g), 32'(ok), 32'd1);
          if (ok) begin
            cur_a = (RAW == 16) ? e.a : {8'h00, e.a[7:0]};
            cur_d = e.d;
            chk($sformatf("wr_reg_addr[%0d]", g), 32'(wa_w[g]), 32'(cur_a));
            chk($sformatf("wr_data[%0d]", g), 32'(wd_w[g]), 32'(cur_d));
            if (e.gap >= 0) chk($sformatf("wr_req_low_gap[%0d]", g), lowc, e.gap);
          end else begin
            cur_a = wa_w[g];
            cur_d = wd_w[g];
          end
          unstable = 1'b0;
        end else if (req_w[g] && (wa_w[g] !== cur_a || wd_w[g] !== cur_d)) begin
          unstable = 1'b1;
        end
        if (!req_w[g] && prev) begin
          chk($sformatf("wr_stable[%0d]", g), 32'(unstable), 32'd0);
          lowc = 0;
        end
        if (!req_w[g]) lowc++;
        prev = req_w[g];
      end
    end
  end

  task automatic clear_table();
    for (int i = 0; i < 8; i++) begin
      t_cmd[i] = 2'b10; t_addr[i] = '0; t_val[i] = '0; nack_plan[i] = 0;
    end
  endtask

  task automatic set_entry(input int i, input logic [1:0] c, input logic [15:0] a,
                           input logic [7:0] v, input int nk);
    t_cmd[i] = c; t_addr[i] = a; t_val[i] = v; nack_plan[i] = nk;
  endtask

  task automatic push_exp(input logic [15:0] a, input logic [7:0] d, input int gap);
    exp_t e;
    e.a = a; e.d = d; e.gap = gap;
    q0.push_back(e);
    q1.push_back(e);
  endtask

  // Each non-write entry costs fetch+wait+decode+next (4 clk) plus its delay; a write costs
  // next after the previous ack, then fetch+wait+decode before wr_req rises; a retry gap is 1 clk.
  task automatic build_model();
    int acc;
    bit first;
    acc = 0; first = 1'b1;
    exp_done = 1'b0; exp_err = 1'b1; exp_ecnt = 7;
    for (int i = 0; i < 8; i++) begin
      if (t_cmd[i] == 2'b00) begin
        int n;
        n = (nack_plan[i] > RM) ? RM + 1 : nack_plan[i] + 1;
        for (int k = 0; k < n; k++)
          push_exp(t_addr[i], t_val[i], (k > 0) ? 1 : (first ? -1 : acc + 4));
        if (nack_plan[i] > RM) begin exp_ecnt = i; return; end
        first = 1'b0;
        acc = 0;
      end else if (t_cmd[i] == 2'b01) begin
        acc += 4 + int'(t_val[i]) * DU;
      end else if (t_cmd[i] == 2'b10) begin
        exp_done = 1'b1; exp_err = 1'b0; exp_ecnt = i;
        return;
      end else begin
        acc += 4;
      end
    end
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic check_reset(input string nm);
    for (int g = 0; g < 2; g++) begin
      chk($sformatf("%s ctrl[%0d]", nm, g),
          32'({busy_w[g], done_w[g], err_w[g], req_w[g], ecnt_w[g], ra_w[g]}), 32'd0);
      chk($sformatf("%s data[%0d]", nm, g), 32'({wa_w[g], wd_w[g]}), 32'd0);
    end
  endtask

  task automatic run_walk(input string nm, input bit noise);
    int cyc;
    build_model();
    pulse_start();
    @(negedge clk);
    chk({nm, " busy_after_start"}, 32'(busy_w), 32'd3);
    cyc = 0;
    while (busy_w != 2'b00 && cyc < 5000) begin
      if (noise && busy_w == 2'b11 && $urandom_range(0, 15) == 0) begin
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end else begin
        @(negedge clk);
      end
      cyc++;
    end
    chk({nm, " finished_in_time"}, 32'(cyc < 5000), 32'd1);
    repeat (2) @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      chk($sformatf("%s done[%0d]", nm, g), 32'(done_w[g]), 32'(exp_done));
      chk($sformatf("%s error[%0d]", nm, g), 32'(err_w[g]), 32'(exp_err));
      chk($sformatf("%s busy[%0d]", nm, g), 32'(busy_w[g]), 32'd0);
      chk($sformatf("%s entry_cnt[%0d]", nm, g), 32'(ecnt_w[g]), 32'(exp_ecnt));
      chk($sformatf("%s writes_left[%0d]", nm, g), qsize(g), 0);
    end
    q0.delete();
    q1.delete();
  endtask

  initial begin
    int cyc;
    int r;
    reset = 1'b1; start = 1'b0; ack_dly = 0;
    clear_table();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_reset("after_reset");

    // 8-bit table with a 2-unit delay between the two writes, fixed ack latency
    clear_table();
    set_entry(0, 2'b00, 16'h0012, 8'h80, 0);
    set_entry(1, 2'b01, 16'h0000, 8'h02, 0);
    set_entry(2, 2'b00, 16'h003d, 8'h03, 0);
    set_entry(3, 2'b10, 16'h0000, 8'h00, 0);
    ack_dly = 5;
    run_walk("basic", 1'b0);
    ack_dly = 0;

    clear_table();
    set_entry(0, 2'b00, 16'h3008, 8'h82, 0);
    run_walk("addr16", 1'b0);

    clear_table();
    set_entry(0, 2'b00, 16'h1111, 8'h22, 2);
    run_walk("nack_twice", 1'b0);

    clear_table();
    set_entry(0, 2'b00, 16'h0101, 8'h01, 0);
    set_entry(1, 2'b01, 16'h0000, 8'h01, 0);
    set_entry(2, 2'b00, 16'h0202, 8'h02, 4);
    run_walk("nack_exhaust", 1'b0);

    clear_table();
    set_entry(0, 2'b00, 16'h0a0a, 8'h10, 0);
    set_entry(1, 2'b11, 16'h0000, 8'h00, 0);
    set_entry(2, 2'b00, 16'h0b0b, 8'h20, 1);
    set_entry(3, 2'b01, 16'h0000, 8'h00, 0);
    set_entry(4, 2'b00, 16'h0c0c, 8'h30, 0);
    set_entry(5, 2'b01, 16'h0000, 8'h01, 0);
    set_entry(6, 2'b11, 16'h0000, 8'h00, 0);
    set_entry(7, 2'b00, 16'h0d0d, 8'h40, 3);
    run_walk("no_end", 1'b1);

    for (int t = 0; t < 12; t++) begin
      for (int i = 0; i < 8; i++) begin
        r = int'($urandom_range(0, 9));
        t_addr[i] = 16'($urandom);
        t_val[i]  = 8'($urandom);
        nack_plan[i] = ($urandom_range(0, 9) == 0) ? 4 : int'($urandom_range(0, 3));
        if (r <= 4)      t_cmd[i] = 2'b00;
        else if (r <= 6) begin t_cmd[i] = 2'b01; t_val[i] = 8'($urandom_range(0, 3)); end
        else if (r == 7) t_cmd[i] = 2'b11;
        else             t_cmd[i] = 2'b10;
      end
      run_walk($sformatf("random%0d", t), 1'b1);
    end

    // reset while parked in a long delay entry
    clear_table();
    set_entry(0, 2'b00, 16'h5566, 8'h77, 0);
    set_entry(1, 2'b00, 16'h5567, 8'h78, 0);
    set_entry(2, 2'b01, 16'h0000, 8'hff, 0);
    set_entry(3, 2'b00, 16'h5568, 8'h79, 0);
    build_model();
    pulse_start();
    cyc = 0;
    while (!(ecnt_w[0] == 3'd2 && ecnt_w[1] == 3'd2) && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    chk("reach_delay", 32'(cyc < 2000), 32'd1);
    repeat (20) @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      chk($sformatf("busy_in_delay[%0d]", g), 32'(busy_w[g]), 32'd1);
      chk($sformatf("writes_before_reset[%0d]", g), qsize(g), 1);
    end
    reset = 1'b1;
    @(negedge clk);
    check_reset("reset_in_delay");
    reset = 1'b0;
    q0.delete();
    q1.delete();

    clear_table();
    set_entry(0, 2'b00, 16'h4321, 8'h5a, 1);
    run_walk("after_reset_walk", 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/cam_init_sequencer.md
Name: cam_init_sequencer

Overview:
- Parametrised successor to the fixed per-sensor init ROMs; walks an external synchronous register table and issues one SCCB/I2C register write per entry to the existing SCCB master.
- Supports 8-bit (OV7725) and 16-bit (OV5640) register addresses, inline delay entries, an end-of-table marker, NACK retry, and a start/done/error handshake.
- Sits between the init-table ROM and the SCCB master, under camera top-level control.

Parameters:
- REG_ADDR_WIDTH, 8, sensor register address width (8 or 16)
- TBL_ADDR_WIDTH, 8, table index width; at most 2**TBL_ADDR_WIDTH entries
- DELAY_UNIT, 50000, clk cycles per delay count (1 ms at 50 MHz)
- RETRY_MAX, 3, write retries after NACK before error
- ENTRY_WIDTH, 2+REG_ADDR_WIDTH+8, derived; entry = {cmd[1:0], reg_addr, value[7:0]}

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; begins a table walk from index 0
- rom_addr  out  TBL_ADDR_WIDTH  table index to ROM
- rom_q  in  ENTRY_WIDTH  ROM data, valid exactly one clk after rom_addr
- wr_req  out  1  write request to SCCB master; held until wr_done
- wr_reg_addr  out  REG_ADDR_WIDTH  register address, stable while wr_req=1
- wr_data  out  8  register value, stable while wr_req=1
- wr_done  in  1  one-cycle pulse from master: transaction finished
- wr_nack  in  1  qualified by wr_done: 1 = slave NACK
- busy  out  1  high from the cycle after start until DONE/ERROR
- done  out  1  sticky; table completed
- error  out  1  sticky; retries exhausted or table overrun
- entry_cnt  out  TBL_ADDR_WIDTH  index of the current / last processed entry

Behaviour:
- Reset values: rom_addr=0, wr_req=0, wr_reg_addr=0, wr_data=0, busy=0, done=0, error=0, entry_cnt=0. State returns to IDLE. Reset mid-transaction drops wr_req in the same edge; the master is expected to be reset in parallel.
- States:
  - IDLE: on start, go to FETCH; clear done/error; set rom_addr=entry_cnt=0.
  - FETCH: 1 cycle, address presented.
  - WAIT: 1 cycle; rom_q is valid at the end of it and is registered.
  - DECODE on cmd:
    - 00 = WRITE
    - 01 = DELAY, with count = value (0 means no wait, go straight to NEXT)
    - 10 = END, go to DONE
    - 11 = reserved, treated as a skip and go to NEXT
  - WRITE: assert wr_req with the latched address/data; on wr_done && !wr_nack go to NEXT.
    - On wr_done && wr_nack: increment retry count. Deassert wr_req for exactly 1 cycle, then re-request. If the retry count exceeds RETRY_MAX, go to ERROR.
    - Retry count clears on entry to every WRITE.
  - DELAY: counter of value*DELAY_UNIT cycles (32-bit, no overflow for value≤255), then NEXT.
  - NEXT: if entry_cnt == 2**TBL_ADDR_WIDTH-1, go to ERROR (no END marker). Otherwise entry_cnt+1, rom_addr+1, go to FETCH.
  - DONE: busy=0, done=1; wait for start.
  - ERROR: busy=0, error=1; wait for start.
- start is ignored while busy. start in DONE or ERROR restarts from index 0.
- Minimum per-write overhead is 4 clk (FETCH, WAIT, DECODE, first wr_req cycle).
- wr_done while wr_req=0 is ignored.
- Entry 0 is typically a soft-reset write followed by a DELAY entry; the sequencer imposes no special handling for it.
- REG_ADDR_WIDTH=8: reg_addr occupies bits [15:8] of the entry, matching the {addr,data} layout of the existing tables plus the cmd bits above them.

Test Plan:
- REG_ADDR_WIDTH=8, table {00_12_80, 01_00_02, 00_3d_03, 10_00_00}, DELAY_UNIT=10, master acks 5 cycles after req.
  - Required: writes 0x12←0x80 then 0x3d←0x03; exactly 20 clk gap from the delay entry; done=1, entry_cnt=3, error=0.
- REG_ADDR_WIDTH=16, entry {00,16'h3008,8'h82}:
  - Required: wr_reg_addr=16'h3008, wr_data=8'h82, stable for the whole wr_req high period.
- NACK twice then ack, RETRY_MAX=3:
  - Required: three wr_req assertions separated by 1-cycle low gaps; success; done=1.
- NACK 4 times, RETRY_MAX=3:
  - Required: error=1, busy=0, done=0; entry_cnt holds the failing index.
- Table with no END, TBL_ADDR_WIDTH=3:
  - Required: 8 entries processed, then error=1.
- Other sequencing cases:
  - start pulses while busy: ignored.
  - reset asserted during DELAY: all outputs return to reset values next cycle.
  - start after done: restarts at index 0.
